// File: rtl/mips_store_unit.sv
// Store path for SB/SH/SW: narrows the register value, places it in its little-endian lane and
// writes word-wide memory (read-modify-write by default; single lane-enabled write with MIPS_STORE_BYTE_ENABLE_EN).
module mips_store_unit #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
`ifdef MIPS_STORE_BYTE_ENABLE_EN
    output logic [3:0]        mem_be,
`endif
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Valid/ready: a request transfers on a cycle where req_valid and req_ready are both high;
    // req_ready is high only in IDLE and requests seen elsewhere are dropped. mem_req is held
    // with stable addr/we/wdata until the cycle mem_ack is high, or until the wait times out.
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_bad;
    logic              timeout_hit;
    logic [31:0]       wdata_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            size_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        req_bad = (req_size == 2'b11)
               || (req_size == SZ_HALF && req_addr[0])
               || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
        // The counter holds the number of unacknowledged cycles already spent in this state.
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    size_d = req_size;
                    addr_d = req_addr;
                    data_d = req_data;
                    err_d  = req_bad;
                    if (req_bad) begin
                        state_d = S_DONE;
                    end else begin
`ifdef MIPS_STORE_BYTE_ENABLE_EN
                        state_d = S_WRITE;
`else
                        state_d = (req_size == SZ_WORD) ? S_WRITE : S_READ;
`endif
                    end
                end
            end
            S_READ: begin
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    cnt_d   = '0;
                    state_d = S_WRITE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        done      = (state_q == S_DONE);
        err       = (state_q == S_DONE) && err_q;
        mem_req   = (state_q == S_READ) || (state_q == S_WRITE);
        mem_we    = (state_q == S_WRITE);
        mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
`ifdef MIPS_STORE_BYTE_ENABLE_EN
        case (size_q)
            SZ_BYTE: begin
                wdata_w = {4{data_q[7:0]}};
                mem_be  = 4'b0001 << addr_q[1:0];
            end
            SZ_HALF: begin
                wdata_w = {2{data_q[15:0]}};
                mem_be  = 4'b0011 << {addr_q[1], 1'b0};
            end
            default: begin
                wdata_w = data_q;
                mem_be  = 4'b1111;
            end
        endcase
        if (state_q != S_WRITE) mem_be = 4'b0000;
`else
        // Sub-word stores overwrite only their lane of the word read back in READ.
        wdata_w = rdata_q;
        case (size_q)
            SZ_BYTE: wdata_w[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
            SZ_HALF: wdata_w[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
            default: wdata_w = data_q;
        endcase
`endif
        mem_wdata = (state_q == S_WRITE) ? wdata_w : 32'h0;
    end

endmodule

// File: tb/tb_mips_store_unit.sv
// Directed bench for mips_store_unit (TIMEOUT_CYCLES=4) with a zero-wait memory model that can withhold mem_ack.
module tb_mips_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        done;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        ack_en;
`ifdef MIPS_STORE_BYTE_ENABLE_EN
    logic [3:0]  mem_be;
`endif

    int tests = 0;
    int fails = 0;

    int          nr, nw, reqc, lat;
    logic        err_s, rdy_s;
    logic [31:0] ra, wa, wd;
    logic [3:0]  be_s;

    always #5 clk = ~clk;

    assign mem_ack = ack_en & mem_req;

    mips_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .done      (done),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
`ifdef MIPS_STORE_BYTE_ENABLE_EN
        .mem_be    (mem_be),
`endif
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one request for one cycle, then records memory traffic until done (bounded).
    task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_size = sz; req_addr = a; req_data = d;
        rdy_s = req_ready;
        @(negedge clk);
        req_valid = 1'b0;
        nr = 0; nw = 0; reqc = 0; lat = 0; err_s = 1'b0;
        ra = '0; wa = '0; wd = '0; be_s = '0;
        for (int c = 1; c <= 20; c++) begin
            if (mem_req) reqc++;
            if (mem_req && mem_ack) begin
                if (mem_we) begin
                    nw++; wa = mem_addr; wd = mem_wdata;
`ifdef MIPS_STORE_BYTE_ENABLE_EN
                    be_s = mem_be;
`endif
                end else begin
                    nr++; ra = mem_addr;
                end
            end
            if (done) begin
                lat = c; err_s = err;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_size = '0; req_addr = '0; req_data = '0;
        mem_rdata = '0; ack_en = 1'b1;
        #1;
        check("rst_ready", {31'b0, req_ready}, 32'h1);
        check("rst_mem_req", {31'b0, mem_req}, 32'h0);
        check("rst_done_err", {30'b0, done, err}, 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a stalled write.
        ack_en = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_size = 2'b10; req_addr = 32'h0000_0500; req_data = 32'h1234_5678;
        @(negedge clk);
        req_valid = 1'b0;
        check("midwr_mem_req", {31'b0, mem_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("midwr_rst_mem_req", {31'b0, mem_req}, 32'h0);
        check("midwr_rst_mem_we", {31'b0, mem_we}, 32'h0);
        check("midwr_rst_addr", mem_addr, 32'h0);
        check("midwr_rst_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'b0, req_ready}, 32'h1);
        check("post_rst_done_err", {30'b0, done, err}, 32'h0);
        ack_en = 1'b1;

`ifndef MIPS_STORE_BYTE_ENABLE_EN
        mem_rdata = 32'h1122_3344;
        do_store(2'b00, 32'h0000_0103, 32'hFFFF_FFA5);
        check("sb_ready", {31'b0, rdy_s}, 32'h1);
        check("sb_reads", nr, 1);
        check("sb_raddr", ra, 32'h0000_0100);
        check("sb_writes", nw, 1);
        check("sb_waddr", wa, 32'h0000_0100);
        check("sb_wdata", wd, 32'hA522_3344);
        check("sb_latency", lat, 3);
        check("sb_err", {31'b0, err_s}, 32'h0);

        do_store(2'b00, 32'h0000_0101, 32'h0000_0077);
        check("sb1_wdata", wd, 32'h1122_7744);

        mem_rdata = 32'hCAFE_1234;
        do_store(2'b01, 32'h0000_0202, 32'h0000_BEEF);
        check("sh_waddr", wa, 32'h0000_0200);
        check("sh_wdata", wd, 32'hBEEF_1234);
        check("sh_latency", lat, 3);

        do_store(2'b01, 32'h0000_0200, 32'h1234_ABCD);
        check("sh0_wdata", wd, 32'hCAFE_ABCD);
`else
        mem_rdata = 32'h1122_3344;
        do_store(2'b00, 32'h0000_0103, 32'hFFFF_FFA5);
        check("be_sb_reads", nr, 0);
        check("be_sb_writes", nw, 1);
        check("be_sb_waddr", wa, 32'h0000_0100);
        check("be_sb_wdata", wd, 32'hA5A5_A5A5);
        check("be_sb_be", {28'b0, be_s}, 32'h8);
        check("be_sb_latency", lat, 2);

        do_store(2'b01, 32'h0000_0202, 32'h0000_BEEF);
        check("be_sh_wdata", wd, 32'hBEEF_BEEF);
        check("be_sh_be", {28'b0, be_s}, 32'hC);
        check("be_sh_latency", lat, 2);
`endif

        do_store(2'b10, 32'h0000_0300, 32'hDEAD_BEEF);
        check("sw_reads", nr, 0);
        check("sw_writes", nw, 1);
        check("sw_waddr", wa, 32'h0000_0300);
        check("sw_wdata", wd, 32'hDEAD_BEEF);
        check("sw_latency", lat, 2);
        check("sw_err", {31'b0, err_s}, 32'h0);
`ifdef MIPS_STORE_BYTE_ENABLE_EN
        check("be_sw_be", {28'b0, be_s}, 32'hF);
`endif

        do_store(2'b01, 32'h0000_0201, 32'h0000_1111);
        check("sh_mis_latency", lat, 1);
        check("sh_mis_err", {31'b0, err_s}, 32'h1);
        check("sh_mis_memreq", reqc, 0);

        do_store(2'b11, 32'h0000_0000, 32'h0000_2222);
        check("rsv_latency", lat, 1);
        check("rsv_err", {31'b0, err_s}, 32'h1);
        check("rsv_memreq", reqc, 0);

        do_store(2'b10, 32'h0000_0302, 32'h0000_3333);
        check("sw_mis_err", {31'b0, err_s}, 32'h1);
        check("sw_mis_memreq", reqc, 0);

        // No acknowledge at all: four request cycles, then done with err.
        ack_en = 1'b0;
        do_store(2'b10, 32'h0000_0400, 32'h5555_5555);
        check("tmo_req_cycles", reqc, 4);
        check("tmo_latency", lat, 5);
        check("tmo_err", {31'b0, err_s}, 32'h1);
        check("tmo_writes", nw, 0);
        ack_en = 1'b1;

        @(negedge clk);
        check("end_ready", {31'b0, req_ready}, 32'h1);
        check("end_done", {31'b0, done}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
